mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the max cycles from issue to mem_*_ok before an error response (8-bit counter).
REQ-002 clock  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-004 if_req_valid / if_req_ready  in / out  1 / 1  fetch-request handshake.
REQ-005 if_req_addr  in  32  fetch read address.
REQ-006 if_resp_valid / if_resp_ready  out / in  1 / 1  fetch-response handshake.
REQ-007 if_resp_data, if_resp_err  out  32, 1  fetch read data; timeout error flag.
REQ-008 ls_req_valid / ls_req_ready  in / out  1 / 1  load/store request handshake.
REQ-009 ls_req_wen, ls_req_addr  in  1, 32  1 = store, 0 = load; byte address.
REQ-010 ls_req_wdata, ls_req_wmask  in  32, 8  store data and byte mask.
REQ-011 ls_resp_valid / ls_resp_ready  out / in  1 / 1  LSU response handshake (loads and stores).
REQ-012 ls_resp_rdata, ls_resp_err  out  32, 1  load data (0 for stores); timeout error flag.
REQ-013 mem_ld_wen, mem_st_wen  out  1, 1  one-cycle read/write issue strobes to the DPI SRAM.
REQ-014 mem_raddr, mem_waddr, mem_wdata, mem_wmask  out  32, 32, 32, 8  SRAM request fields.
REQ-015 mem_rdata, mem_rdata_ok, mem_wdata_ok  in  32, 1, 1  SRAM read data and completion pulses.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one SRAM transaction outstanding at any time.
REQ-017 IDLE: if_req_ready/ls_req_ready high only in IDLE and only for the granted requester; a handshake latches the request and moves to ISSUE.
REQ-018 Arbitration in IDLE: single valid wins; both valid -> round-robin via last_grant bit (requester not served last wins); last_grant reset value = LSU (so IFU wins first tie).
REQ-019 ISSUE (exactly one cycle): mem_ld_wen = 1 for IFU or LSU load, mem_st_wen = 1 for store, address/data/mask driven from latched request; next state WAIT.
REQ-020 All mem_* outputs are registered; mem_ld_wen/mem_st_wen are 0 in every state except ISSUE; mem_wdata/mem_wmask are 0 when not storing.
REQ-021 WAIT: on mem_rdata_ok (read) capture mem_rdata, or on mem_wdata_ok (store) capture nothing; either -> RESP with err = 0; the ok of the wrong type is ignored.
REQ-022 WAIT timeout: counter cleared at ISSUE, increments each WAIT cycle; reaching TIMEOUT -> RESP with err = 1, data = 0.
REQ-023 ok arriving in the same cycle the counter reaches TIMEOUT: success wins, err = 0.
REQ-024 RESP: resp_valid asserted to the owning requester only, data/err held stable until resp_ready; handshake -> IDLE and last_grant updated.
REQ-025 Request-to-response minimum latency: handshake cycle N, ISSUE N+1, ok sampled N+2 (dpi_sram latency), resp_valid N+3.
REQ-026 A new request is never accepted in the RESP->IDLE handshake cycle (no bypass); back-to-back throughput is one transaction per 4 cycles.
REQ-027 ok pulses received in IDLE, ISSUE or RESP are ignored and raise no response.

Reset
REQ-028 On reset low: state = IDLE, last_grant = LSU, counter = 0, all valid/ready/strobe outputs 0, all data/address outputs 0, asynchronously.
REQ-029 Reset asserted mid-transaction discards it; no response is issued after reset release.

Structure
REQ-030 Shared package holds the state enum, requester-id enum (REQ_IF, REQ_LS) and default TIMEOUT constant.
REQ-031 Single module; the timeout counter is inline, no sub-modules.

Verification
REQ-032 IFU alone reads 0x8000_0000, model returns 0x0000_0413 after 1 cycle -> if_resp_valid at N+3, data 0x0000_0413, err 0.
REQ-033 LSU store 0x8000_0010, wdata 0xDEADBEEF, wmask 0x0F -> mem_st_wen pulse exactly 1 cycle with those fields; ls_resp_valid, rdata 0, err 0.
REQ-034 Both valid every cycle for 8 transactions -> grants alternate IF, LS, IF, LS...; never two strobes outstanding.
REQ-035 Model never returns ok, TIMEOUT = 4 -> resp_valid with err = 1, data 0, after 4 WAIT cycles; next request served normally.
REQ-036 resp_ready held low 5 cycles -> resp data/err stable, req_ready stays 0; reset pulsed during WAIT -> all outputs 0, no late response.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   typedef enum logic {
      REQ_IF,
      REQ_LS
   } req_id_e;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and SRAM handshakes around the memory arbiter.
interface mem_arbiter_if;

   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_req_addr;
   logic        if_resp_valid;
   logic        if_resp_ready;
   logic [31:0] if_resp_data;
   logic        if_resp_err;

   logic        ls_req_valid;
   logic        ls_req_ready;
   logic        ls_req_wen;
   logic [31:0] ls_req_addr;
   logic [31:0] ls_req_wdata;
   logic [7:0]  ls_req_wmask;
   logic        ls_resp_valid;
   logic        ls_resp_ready;
   logic [31:0] ls_resp_rdata;
   logic        ls_resp_err;

   logic        mem_ld_wen;
   logic        mem_st_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_rdata_ok;
   logic        mem_wdata_ok;

   modport slave (
      input  if_req_valid, if_req_addr, if_resp_ready,
      input  ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_ready,
      input  mem_rdata, mem_rdata_ok, mem_wdata_ok,
      output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      output ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
      output mem_ld_wen, mem_st_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output if_req_valid, if_req_addr, if_resp_ready,
      output ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_ready,
      output mem_rdata, mem_rdata_ok, mem_wdata_ok,
      input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      input  ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
      input  mem_ld_wen, mem_st_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU requests onto the single-port DPI SRAM, one transaction in flight,
// round-robin on ties, with an error response when the SRAM does not answer within TIMEOUT cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   arb_state_e  state;
   arb_state_e  next_state;
   req_id_e     last_grant;
   req_id_e     owner;
   logic        is_store;
   logic [7:0]  wait_count;
   logic [31:0] resp_data;
   logic        resp_err;

   logic grant_if;
   logic grant_ls;
   logic ok_hit;
   logic timed_out;
   logic resp_taken;

   // The requester not served last wins a tie; an ok of the wrong type never completes.
   always_comb begin
      grant_if   = bus.if_req_valid && (!bus.ls_req_valid || last_grant == REQ_LS);
      grant_ls   = bus.ls_req_valid && !grant_if;
      ok_hit     = is_store ? bus.mem_wdata_ok : bus.mem_rdata_ok;
      timed_out  = (wait_count == TIMEOUT_LAST);
      resp_taken = (owner == REQ_IF) ? bus.if_resp_ready : bus.ls_resp_ready;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state        = state;
      bus.if_req_ready  = 1'b0;
      bus.ls_req_ready  = 1'b0;
      bus.if_resp_valid = 1'b0;
      bus.if_resp_data  = '0;
      bus.if_resp_err   = 1'b0;
      bus.ls_resp_valid = 1'b0;
      bus.ls_resp_rdata = '0;
      bus.ls_resp_err   = 1'b0;
      case (state)
         IDLE: begin
            bus.if_req_ready = reset && grant_if;
            bus.ls_req_ready = reset && grant_ls;
            if (grant_if || grant_ls) next_state = ISSUE;
         end
         ISSUE: next_state = WAIT;
         WAIT: begin
            if (ok_hit || timed_out) next_state = RESP;
         end
         RESP: begin
            if (owner == REQ_IF) begin
               bus.if_resp_valid = 1'b1;
               bus.if_resp_data  = resp_data;
               bus.if_resp_err   = resp_err;
            end else begin
               bus.ls_resp_valid = 1'b1;
               bus.ls_resp_rdata = resp_data;
               bus.ls_resp_err   = resp_err;
            end
            if (resp_taken) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // SRAM fields are loaded on the accepting edge so they appear registered during ISSUE only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant     <= REQ_LS;
         owner          <= REQ_IF;
         is_store       <= 1'b0;
         wait_count     <= '0;
         resp_data      <= '0;
         resp_err       <= 1'b0;
         bus.mem_ld_wen <= 1'b0;
         bus.mem_st_wen <= 1'b0;
         bus.mem_raddr  <= '0;
         bus.mem_waddr  <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_wmask  <= '0;
      end else begin
         bus.mem_ld_wen <= 1'b0;
         bus.mem_st_wen <= 1'b0;
         bus.mem_raddr  <= '0;
         bus.mem_waddr  <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_wmask  <= '0;
         case (state)
            IDLE: begin
               if (grant_if) begin
                  owner          <= REQ_IF;
                  is_store       <= 1'b0;
                  bus.mem_ld_wen <= 1'b1;
                  bus.mem_raddr  <= bus.if_req_addr;
               end else if (grant_ls) begin
                  owner    <= REQ_LS;
                  is_store <= bus.ls_req_wen;
                  if (bus.ls_req_wen) begin
                     bus.mem_st_wen <= 1'b1;
                     bus.mem_waddr  <= bus.ls_req_addr;
                     bus.mem_wdata  <= bus.ls_req_wdata;
                     bus.mem_wmask  <= bus.ls_req_wmask;
                  end else begin
                     bus.mem_ld_wen <= 1'b1;
                     bus.mem_raddr  <= bus.ls_req_addr;
                  end
               end
            end
            ISSUE: wait_count <= '0;
            WAIT: begin
               if (ok_hit) begin
                  resp_data <= is_store ? 32'h0 : bus.mem_rdata;
                  resp_err  <= 1'b0;
               end else if (timed_out) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
               end else begin
                  wait_count <= wait_count + 8'd1;
               end
            end
            RESP: begin
               if (resp_taken) last_grant <= owner;
            end
            default: ;
         endcase
      end
   end

endmodule
